stack_sequencer: RTL and testbench
==================================

STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 Parameter DATA_W, 32, operand/result width.
REQ-002 Parameter DEPTH, 16, max stack entries (TOS register plus DEPTH-1 RAM words).
REQ-003 Parameter ADDR_W, 4, RAM address width; the design SHALL require 2**ADDR_W >= DEPTH-1.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  sequencer idle; a command is accepted when cmd_valid && cmd_ready at a clock edge.
REQ-008 cmd_op  in  2  00 PUSH, 01 POP, 10 ALU, 11 CLEAR.
REQ-009 cmd_data  in  DATA_W  PUSH operand.
REQ-010 alu_a / alu_b  out  DATA_W  ALU operands: alu_a = next-on-stack (NOS), alu_b = TOS.
REQ-011 alu_result  in  DATA_W  combinational ALU output.
REQ-012 mem_we, mem_addr[ADDR_W], mem_wdata[DATA_W]  out  stack RAM port, all registered.
REQ-013 mem_rdata  in  DATA_W  RAM read data, valid one cycle after RAM samples mem_addr.
REQ-014 tos  out  DATA_W  top-of-stack register.
REQ-015 count  out  ADDR_W+1  entries held, 0..DEPTH.
REQ-016 full, empty  out  1  count==DEPTH, count==0.
REQ-017 err  out  1  one-cycle pulse on a rejected command.

Function
REQ-018 The sequencer SHALL use FSM states IDLE, RD1, RD2, EXEC; cmd_ready SHALL equal (state==IDLE).
REQ-019 Storage SHALL be: TOS in the tos register; entry k below TOS at mem[count-1-k].
REQ-020 PUSH, not full: in the accept cycle, register mem_we=1, mem_addr=count-1, mem_wdata=tos only if count>=1; set tos=cmd_data and count+1; remain in IDLE.
REQ-021 mem_we SHALL be high for exactly one cycle per write and low otherwise.
REQ-022 POP with count==1: tos=0, count=0; remain in IDLE.
REQ-023 POP with count>=2: register mem_addr=count-2 and go to RD1. RD1 goes to RD2. In RD2, tos=mem_rdata and count-1, then go to IDLE. Total 3 cycles.
REQ-024 ALU with count>=2: go to RD1 then RD2 as in POP. In RD2, latch NOS from mem_rdata. In EXEC, alu_a=NOS and alu_b=tos are held stable; at EXEC end, tos=alu_result and count-1; go to IDLE. Total 4 cycles.
REQ-025 CLEAR: count=0 and tos=0 in one cycle; RAM contents are untouched.
REQ-026 The following SHALL be rejected: PUSH when full, POP when empty, ALU when count<2. For a rejected command, err=1 in the next cycle, no state/count/tos/RAM change, and the FSM stays in IDLE.
REQ-027 cmd_valid while cmd_ready=0 SHALL be ignored; the requester holds the command.
REQ-028 A write registered in cycle N SHALL complete before any read whose address is registered in cycle N+1 (PUSH followed immediately by POP returns the pushed-under value).
REQ-029 alu_a/alu_b SHALL hold their last values outside EXEC.

Reset
REQ-030 On rst: state=IDLE, count=0, tos=0, NOS=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, alu_a=alu_b=0. cmd_ready=1 and empty=1 once rst deasserts.
REQ-031 Reset during RD1/RD2/EXEC SHALL abort the operation with no RAM write and no tos update.

Structure
REQ-032 Package stack_seq_pkg SHALL hold the op-code constants, the FSM state encoding, and the DATA_W/DEPTH defaults.
REQ-033 The controller SHALL contain no sub-modules.
REQ-034 Sub-module stack_ram (single-port, synchronous-read RAM, 2**ADDR_W x DATA_W) SHALL be provided for the integration wrapper and bench.

Verification
REQ-035 PUSH 5, PUSH 3, ALU with ALU=a+b -> tos=8, count=1, one mem write of 5 to addr 0, cmd_ready low for 3 cycles.
REQ-036 PUSH 10, PUSH 4, ALU with ALU=a-b -> alu_a=10, alu_b=4 in EXEC, tos=6.
REQ-037 16 PUSHes of 1..16 -> full=1, tos=16. A 17th PUSH -> err pulse, tos=16, count=16. Then 16 POPs -> tos sequence 15..1, then 0; empty=1.
REQ-038 POP when empty and ALU with count=1 -> err pulse each time, count/tos unchanged.
REQ-039 PUSH 7 then POP in the next cycle over a 3-entry stack -> tos equals the prior value below 7, count restored.
REQ-040 rst asserted during RD2 of an ALU -> count=0, tos=0, mem_we never asserted, cmd_ready=1 after release.

Source files
------------

// File: rtl/stack_seq_pkg.sv
// Shared constants for the stack sequencer: op-codes, FSM encoding and parameter defaults.
package stack_seq_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefDepth = 16;
  localparam int unsigned DefAddrW = 4;

  typedef enum logic [1:0] {
    OpPush  = 2'b00,
    OpPop   = 2'b01,
    OpAlu   = 2'b10,
    OpClear = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRd1  = 2'b01,
    StRd2  = 2'b10,
    StExec = 2'b11
  } state_e;

endpackage

// File: rtl/stack_sequencer_if.sv
// Command, ALU and stack-RAM signals of the stack sequencer grouped into one bundle.
interface stack_sequencer_if #(
  parameter int unsigned DATA_W = stack_seq_pkg::DefDataW,
  parameter int unsigned ADDR_W = stack_seq_pkg::DefAddrW
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  stack_seq_pkg::op_e      cmd_op;
  logic [DATA_W-1:0]       cmd_data;
  logic [DATA_W-1:0]       alu_a;
  logic [DATA_W-1:0]       alu_b;
  logic [DATA_W-1:0]       alu_result;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;
  logic [DATA_W-1:0]       tos;
  logic [ADDR_W:0]         count;
  logic                    full;
  logic                    empty;
  logic                    err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, alu_result, mem_rdata,
    input  cmd_ready, alu_a, alu_b, mem_we, mem_addr, mem_wdata, tos, count, full, empty, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, alu_result, mem_rdata,
    output cmd_ready, alu_a, alu_b, mem_we, mem_addr, mem_wdata, tos, count, full, empty, err
  );

endinterface

// File: rtl/stack_ram.sv
// Single-port stack RAM with synchronous read; read returns the pre-write contents.
module stack_ram #(
  parameter int unsigned DATA_W = stack_seq_pkg::DefDataW,
  parameter int unsigned ADDR_W = stack_seq_pkg::DefAddrW
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/stack_sequencer.sv
// Stack controller: TOS held in a register, deeper entries spilled to an external
// synchronous RAM; POP/ALU refill the TOS through a two-cycle read.
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input logic              clk,
  input logic              rst,
  stack_sequencer_if.slave bus
);

  localparam int unsigned     CntW    = ADDR_W + 1;
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntTwo  = CntW'(2);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  if ((2 ** ADDR_W) < (DEPTH - 1)) begin : g_addr_w_check
    $error("stack_sequencer: ADDR_W too small to hold DEPTH-1 RAM entries");
  end

  state_e            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_tos, w_tos_nxt;
  logic [CntW-1:0]   r_count, w_count_nxt;
  logic [DATA_W-1:0] r_nos, w_nos_nxt;
  logic [DATA_W-1:0] r_alu_b, w_alu_b_nxt;
  logic              r_is_alu, w_is_alu_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              r_err, w_err_nxt;
  logic              w_full, w_empty;

  assign w_full  = (r_count == CntFull);
  assign w_empty = (r_count == '0);

  always_comb begin
    w_state_nxt     = r_state;
    w_tos_nxt       = r_tos;
    w_count_nxt     = r_count;
    w_nos_nxt       = r_nos;
    w_alu_b_nxt     = r_alu_b;
    w_is_alu_nxt    = r_is_alu;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_err_nxt       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bus.cmd_valid) begin
          unique case (bus.cmd_op)
            OpPush: begin
              if (w_full) begin
                w_err_nxt = 1'b1;
              end else begin
                // Spill the old TOS only when there is one to spill.
                if (!w_empty) begin
                  w_mem_we_nxt    = 1'b1;
                  w_mem_addr_nxt  = ADDR_W'(r_count - CntOne);
                  w_mem_wdata_nxt = r_tos;
                end
                w_tos_nxt   = bus.cmd_data;
                w_count_nxt = r_count + CntOne;
              end
            end
            OpPop: begin
              if (w_empty) begin
                w_err_nxt = 1'b1;
              end else if (r_count == CntOne) begin
                w_tos_nxt   = '0;
                w_count_nxt = '0;
              end else begin
                w_mem_addr_nxt = ADDR_W'(r_count - CntTwo);
                w_is_alu_nxt   = 1'b0;
                w_state_nxt    = StRd1;
              end
            end
            OpAlu: begin
              if (r_count < CntTwo) begin
                w_err_nxt = 1'b1;
              end else begin
                w_mem_addr_nxt = ADDR_W'(r_count - CntTwo);
                w_is_alu_nxt   = 1'b1;
                w_state_nxt    = StRd1;
              end
            end
            OpClear: begin
              w_tos_nxt   = '0;
              w_count_nxt = '0;
            end
          endcase
        end
      end
      StRd1: begin
        // RAM samples the address this cycle; data is available in StRd2.
        w_state_nxt = StRd2;
      end
      StRd2: begin
        if (r_is_alu) begin
          w_nos_nxt   = bus.mem_rdata;
          w_alu_b_nxt = r_tos;
          w_state_nxt = StExec;
        end else begin
          w_tos_nxt   = bus.mem_rdata;
          w_count_nxt = r_count - CntOne;
          w_state_nxt = StIdle;
        end
      end
      StExec: begin
        w_tos_nxt   = bus.alu_result;
        w_count_nxt = r_count - CntOne;
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_tos       <= '0;
      r_count     <= '0;
      r_nos       <= '0;
      r_alu_b     <= '0;
      r_is_alu    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tos       <= w_tos_nxt;
      r_count     <= w_count_nxt;
      r_nos       <= w_nos_nxt;
      r_alu_b     <= w_alu_b_nxt;
      r_is_alu    <= w_is_alu_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign bus.cmd_ready = (r_state == StIdle);
  assign bus.alu_a     = r_nos;
  assign bus.alu_b     = r_alu_b;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.tos       = r_tos;
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with an external stack_ram and a switchable add/sub ALU.
module tb_stack_sequencer;
  import stack_seq_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned DP = 16;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic alu_sub = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;
  int   we_cnt   = 0;
  int   we_base;
  int   busy;

  stack_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  stack_sequencer #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  stack_ram #(.DATA_W(DW), .ADDR_W(AW)) u_ram (
    .clk     (clk),
    .i_we    (bus.mem_we),
    .i_addr  (bus.mem_addr),
    .i_wdata (bus.mem_wdata),
    .o_rdata (bus.mem_rdata)
  );

  assign bus.alu_result = alu_sub ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);

  always #5 clk = ~clk;

  // Counts clock cycles during which a RAM write is presented.
  always @(posedge clk) if (bus.mem_we === 1'b1) we_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input op_e op, input logic [DW-1:0] d);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n_busy);
    n_busy = 0;
    while (bus.cmd_ready !== 1'b1 && n_busy < 10) begin
      step();
      n_busy++;
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OpPush;
    bus.cmd_data  = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_tos", 64'(bus.tos), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_alu_a", 64'(bus.alu_a), 64'd0);
    chk("rst_alu_b", 64'(bus.alu_b), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rel_empty", 64'(bus.empty), 64'd1);

    // PUSH 5, PUSH 3, ADD -> 8
    we_base = we_cnt;
    issue(OpPush, 32'd5);
    chk("p5_tos", 64'(bus.tos), 64'd5);
    chk("p5_count", 64'(bus.count), 64'd1);
    chk("p5_no_we", 64'(bus.mem_we), 64'd0);
    issue(OpPush, 32'd3);
    chk("p3_we", 64'(bus.mem_we), 64'd1);
    chk("p3_addr", 64'(bus.mem_addr), 64'd0);
    chk("p3_wdata", 64'(bus.mem_wdata), 64'd5);
    chk("p3_count", 64'(bus.count), 64'd2);
    issue(OpAlu, 32'd0);
    chk("add_busy0", 64'(bus.cmd_ready), 64'd0);
    wait_ready(busy);
    chk("add_busy_cycles", 64'(busy), 64'd3);
    chk("add_tos", 64'(bus.tos), 64'd8);
    chk("add_count", 64'(bus.count), 64'd1);
    chk("add_we_total", 64'(we_cnt - we_base), 64'd1);

    // PUSH 10, PUSH 4, SUB -> 6, operands visible in EXEC
    issue(OpClear, 32'd0);
    chk("clr_count", 64'(bus.count), 64'd0);
    chk("clr_tos", 64'(bus.tos), 64'd0);
    alu_sub = 1'b1;
    issue(OpPush, 32'd10);
    issue(OpPush, 32'd4);
    issue(OpAlu, 32'd0);
    step();
    step();
    chk("sub_exec_busy", 64'(bus.cmd_ready), 64'd0);
    chk("sub_alu_a", 64'(bus.alu_a), 64'd10);
    chk("sub_alu_b", 64'(bus.alu_b), 64'd4);
    wait_ready(busy);
    chk("sub_tos", 64'(bus.tos), 64'd6);
    chk("sub_count", 64'(bus.count), 64'd1);
    chk("sub_alu_a_hold", 64'(bus.alu_a), 64'd10);
    alu_sub = 1'b0;

    // Fill to DEPTH, overflow, then drain
    issue(OpClear, 32'd0);
    for (int i = 1; i <= 16; i++) issue(OpPush, DW'(i));
    chk("fill_full", 64'(bus.full), 64'd1);
    chk("fill_tos", 64'(bus.tos), 64'd16);
    chk("fill_count", 64'(bus.count), 64'd16);
    issue(OpPush, 32'd17);
    chk("ovf_err", 64'(bus.err), 64'd1);
    chk("ovf_tos", 64'(bus.tos), 64'd16);
    chk("ovf_count", 64'(bus.count), 64'd16);
    chk("ovf_no_we", 64'(bus.mem_we), 64'd0);
    step();
    chk("ovf_err_pulse", 64'(bus.err), 64'd0);
    for (int i = 1; i <= 16; i++) begin
      issue(OpPop, 32'd0);
      wait_ready(busy);
      chk("drain_tos", 64'(bus.tos), 64'(16 - i));
      chk("drain_count", 64'(bus.count), 64'(16 - i));
    end
    chk("drain_empty", 64'(bus.empty), 64'd1);
    chk("drain_full", 64'(bus.full), 64'd0);

    // Underflow and ALU with a single entry
    issue(OpPop, 32'd0);
    chk("udf_err", 64'(bus.err), 64'd1);
    chk("udf_count", 64'(bus.count), 64'd0);
    step();
    chk("udf_err_pulse", 64'(bus.err), 64'd0);
    issue(OpPush, 32'd9);
    issue(OpAlu, 32'd0);
    chk("alu1_err", 64'(bus.err), 64'd1);
    chk("alu1_count", 64'(bus.count), 64'd1);
    chk("alu1_tos", 64'(bus.tos), 64'd9);
    chk("alu1_ready", 64'(bus.cmd_ready), 64'd1);

    // PUSH immediately followed by POP reads the value just spilled
    issue(OpClear, 32'd0);
    issue(OpPush, 32'd21);
    issue(OpPush, 32'd22);
    issue(OpPush, 32'd23);
    issue(OpPush, 32'd7);
    issue(OpPop, 32'd0);
    wait_ready(busy);
    chk("b2b_busy", 64'(busy), 64'd2);
    chk("b2b_tos", 64'(bus.tos), 64'd23);
    chk("b2b_count", 64'(bus.count), 64'd3);

    // Reset during RD2 of an ALU op
    issue(OpClear, 32'd0);
    issue(OpPush, 32'd1);
    issue(OpPush, 32'd2);
    step();
    we_base = we_cnt;
    issue(OpAlu, 32'd0);
    step();
    rst = 1'b1;
    #1;
    chk("abort_count", 64'(bus.count), 64'd0);
    chk("abort_tos", 64'(bus.tos), 64'd0);
    chk("abort_we", 64'(bus.mem_we), 64'd0);
    step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready", 64'(bus.cmd_ready), 64'd1);
    chk("abort_empty", 64'(bus.empty), 64'd1);
    chk("abort_we_total", 64'(we_cnt - we_base), 64'd0);
    chk("abort_alu_a", 64'(bus.alu_a), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
